// File: rtl/mprj_cfg_xfer_wb.sv
// Wishbone slave holding per-pad IO configuration and power-control registers,
// plus a serial engine that shifts every pad configuration into the padframe
// daisy chain (last pad first, MSB first) and then pulses the load strobe.
module mprj_cfg_xfer_wb #(
  parameter logic [31:0]         BASE_ADR  = 32'h2300_0000,
  parameter int                  N_PADS    = 38,
  parameter int                  CFG_BITS  = 13,
  parameter logic [CFG_BITS-1:0] CFG_RESET = 13'h0403,
  parameter int                  N_PWR     = 4,
  parameter int                  CLK_DIV   = 2
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wb_stb_i,
  input  logic              wb_cyc_i,
  input  logic              wb_we_i,
  input  logic [3:0]        wb_sel_i,
  input  logic [31:0]       wb_adr_i,
  input  logic [31:0]       wb_dat_i,
  output logic              wb_ack_o,
  output logic [31:0]       wb_dat_o,
  output logic [N_PWR-1:0]  pwr_ctrl_out,
  output logic              serial_clock,
  output logic              serial_data_out,
  output logic              serial_load,
  output logic              xfer_busy,
  output logic              xfer_done
);
  localparam int PAD_W = (N_PADS > 1) ? $clog2(N_PADS) : 1;
  localparam int BIT_W = (CFG_BITS > 1) ? $clog2(CFG_BITS) : 1;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PAD_W-1:0] LAST_PAD = PAD_W'(N_PADS - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(CFG_BITS - 1);
  localparam logic [DIV_W-1:0] DIV_END  = DIV_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_LOAD} state_t;

  state_t               state_reg;
  logic [CFG_BITS-1:0]  cfg_reg [N_PADS];
  logic [N_PWR-1:0]     pwr_reg;
  logic                 ack_reg;
  logic [31:0]          dat_reg;
  logic                 start_reg;
  logic [PAD_W-1:0]     pad_reg;
  logic [BIT_W-1:0]     bit_reg;
  logic [DIV_W-1:0]     div_reg;
  logic                 sclk_reg, sdata_reg, sload_reg, busy_reg, done_reg;

  // Address decode: a request is new only while ack is low, which keeps
  // one ack per request and never two acks back to back.
  logic        req_new;
  logic [9:0]  word;
  logic [9:0]  cfg_idx;
  logic        hit_xfer, hit_pwr, hit_cfg;
  logic        cfg_wr, pwr_wr, start_next;
  logic [31:0] wmask;
  logic [31:0] rd_val;
  logic [N_PADS-1:0]   cfg_we;
  logic [CFG_BITS-1:0] cfg_mask, cfg_dat;
  logic [N_PWR-1:0]    pwr_next;
  logic                unused_bits;

  assign req_new  = wb_stb_i & wb_cyc_i & (wb_adr_i[31:12] == BASE_ADR[31:12]) & ~ack_reg;
  assign word     = wb_adr_i[11:2];
  assign cfg_idx  = word - 10'd8;
  assign hit_xfer = (word == 10'd0);
  assign hit_pwr  = (word == 10'd1);
  assign hit_cfg  = (word >= 10'd8) && (word < 10'(8 + N_PADS));

  // Configuration writes are dropped while the chain is being shifted.
  assign cfg_wr     = req_new & wb_we_i & hit_cfg & ~busy_reg;
  assign pwr_wr     = req_new & wb_we_i & hit_pwr;
  assign start_next = req_new & wb_we_i & hit_xfer & wb_sel_i[0] & wb_dat_i[0] &
                      ~busy_reg & (state_reg == ST_IDLE);

  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_lane
    assign wmask[8*gi +: 8] = {8{wb_sel_i[gi]}};
  end
  for (gi = 0; gi < N_PADS; gi++) begin : g_pad_we
    assign cfg_we[gi] = cfg_wr && (cfg_idx == 10'(gi));
  end

  assign cfg_mask    = wmask[CFG_BITS-1:0];
  assign cfg_dat     = wb_dat_i[CFG_BITS-1:0];
  assign pwr_next    = (pwr_reg & ~wmask[N_PWR-1:0]) | (wb_dat_i[N_PWR-1:0] & wmask[N_PWR-1:0]);
  assign unused_bits = ^{wb_adr_i[1:0], wb_dat_i, wmask};

  // Read mux: zero-extended register contents, zero for unmapped offsets.
  always_comb begin
    rd_val = '0;
    if (hit_xfer) rd_val = {31'b0, busy_reg};
    else if (hit_pwr) rd_val = 32'(pwr_reg);
    else if (hit_cfg) begin
      for (int i = 0; i < N_PADS; i++) begin
        if (cfg_idx == 10'(i)) rd_val = 32'(cfg_reg[i]);
      end
    end
  end

  // Bus side: ack/read data, byte-lane register writes, transfer request.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_reg   <= 1'b0;
      dat_reg   <= '0;
      pwr_reg   <= '0;
      start_reg <= 1'b0;
      for (int i = 0; i < N_PADS; i++) cfg_reg[i] <= CFG_RESET;
    end else begin
      ack_reg   <= req_new;
      dat_reg   <= req_new ? rd_val : '0;
      start_reg <= start_next;
      if (pwr_wr) pwr_reg <= pwr_next;
      for (int i = 0; i < N_PADS; i++) begin
        if (cfg_we[i]) cfg_reg[i] <= (cfg_reg[i] & ~cfg_mask) | (cfg_dat & cfg_mask);
      end
    end
  end

  // Next chain bit: step down through the bits of a pad, then to the pad below.
  logic [PAD_W-1:0] next_pad;
  logic [BIT_W-1:0] next_bit;
  always_comb begin
    next_pad = pad_reg;
    next_bit = bit_reg - 1'b1;
    if (bit_reg == '0) begin
      next_pad = pad_reg - 1'b1;
      next_bit = LAST_BIT;
    end
  end

  // Serial engine: each bit is CLK_DIV cycles with clock low then CLK_DIV
  // high; after the final bit the load strobe is held for CLK_DIV cycles.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_reg <= ST_IDLE;
      pad_reg   <= '0;
      bit_reg   <= '0;
      div_reg   <= '0;
      sclk_reg  <= 1'b0;
      sdata_reg <= 1'b0;
      sload_reg <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start_reg) begin
            state_reg <= ST_SHIFT;
            busy_reg  <= 1'b1;
            pad_reg   <= LAST_PAD;
            bit_reg   <= LAST_BIT;
            div_reg   <= '0;
            sclk_reg  <= 1'b0;
            sdata_reg <= cfg_reg[LAST_PAD][LAST_BIT];
          end
        end
        ST_SHIFT: begin
          if (div_reg == DIV_END) begin
            div_reg <= '0;
            if (!sclk_reg) begin
              sclk_reg <= 1'b1;
            end else begin
              sclk_reg <= 1'b0;
              if (pad_reg == '0 && bit_reg == '0) begin
                state_reg <= ST_LOAD;
                sload_reg <= 1'b1;
                sdata_reg <= 1'b0;
              end else begin
                pad_reg   <= next_pad;
                bit_reg   <= next_bit;
                sdata_reg <= cfg_reg[next_pad][next_bit];
              end
            end
          end else begin
            div_reg <= div_reg + 1'b1;
          end
        end
        ST_LOAD: begin
          if (div_reg == DIV_END) begin
            state_reg <= ST_IDLE;
            div_reg   <= '0;
            sload_reg <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end else begin
            div_reg <= div_reg + 1'b1;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign wb_ack_o        = ack_reg;
  assign wb_dat_o        = dat_reg;
  assign pwr_ctrl_out    = pwr_reg;
  assign serial_clock    = sclk_reg;
  assign serial_data_out = sdata_reg;
  assign serial_load     = sload_reg;
  assign xfer_busy       = busy_reg;
  assign xfer_done       = done_reg;
endmodule

// File: tb/tb_mprj_cfg_xfer_wb.sv
// Self-checking bench for mprj_cfg_xfer_wb: register map, byte lanes, the
// serial chain waveform cycle by cycle, and reset during a transfer.
module tb_mprj_cfg_xfer_wb;
  localparam int N_PADS = 38, CFG_BITS = 13, N_PWR = 4, CLK_DIV = 2;
  localparam logic [31:0] BASE = 32'h2300_0000;
  localparam int TOTAL     = N_PADS * CFG_BITS;
  localparam int SHIFT_CYC = 2 * CLK_DIV * TOTAL;
  localparam int BUSY_CYC  = SHIFT_CYC + CLK_DIV;

  logic clk = 0, rst = 0, stb = 0, cyc = 0, we = 0;
  logic [3:0] sel = 0;
  logic [31:0] adr = 0, dat = 0;
  logic ack;
  logic [31:0] rdat;
  logic [N_PWR-1:0] pwr;
  logic sclk, sdata, sload, busy, done;

  always #5 clk = ~clk;

  mprj_cfg_xfer_wb dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_stb_i(stb), .wb_cyc_i(cyc), .wb_we_i(we),
    .wb_sel_i(sel), .wb_adr_i(adr), .wb_dat_i(dat), .wb_ack_o(ack), .wb_dat_o(rdat),
    .pwr_ctrl_out(pwr), .serial_clock(sclk), .serial_data_out(sdata),
    .serial_load(sload), .xfer_busy(busy), .xfer_done(done)
  );

  int n_checks = 0, n_fail = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Behavioural model: register contents plus the cycle a transfer starts.
  logic [31:0] m_cfg [N_PADS];
  logic [31:0] m_pwr;
  bit m_active = 0;
  int m_start = 0;
  int cyc_cnt = 0;
  bit chk_en = 0;

  task automatic model_reset();
    for (int i = 0; i < N_PADS; i++) m_cfg[i] = 32'h0403;
    m_pwr = 0;
    m_active = 0;
  endtask

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] cur;
    int w;
    w = int'(a[11:2]);
    cur = 0;
    if (w == 1) cur = m_pwr;
    else if (w >= 8 && w < 8 + N_PADS) cur = m_cfg[w-8];
    for (int b = 0; b < 4; b++) if (s[b]) cur[8*b +: 8] = d[8*b +: 8];
    if (w == 1) m_pwr = cur & ((32'd1 << N_PWR) - 1);
    else if (w >= 8 && w < 8 + N_PADS && !m_active) m_cfg[w-8] = cur & ((32'd1 << CFG_BITS) - 1);
    if (w == 0 && s[0] && d[0] && !m_active) begin
      m_active = 1;
      m_start = cyc_cnt + 1;
    end
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    int w;
    w = int'(a[11:2]);
    if (w == 0) return {31'b0, m_active};
    if (w == 1) return m_pwr;
    if (w >= 8 && w < 8 + N_PADS) return m_cfg[w-8];
    return 0;
  endfunction

  function automatic logic [31:0] cfg_adr(input int i);
    return BASE + 32'h20 + 32'(4 * i);
  endfunction

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Compare process: expected serial lines derived from the transfer start cycle.
  always @(negedge clk) begin
    logic [4:0] exp_v, mask;
    int k, idx;
    if (chk_en) begin
      exp_v = 0;
      mask = 5'b11111;
      if (m_active) begin
        k = cyc_cnt - m_start;
        if (k >= 0 && k < SHIFT_CYC) begin
          idx = TOTAL - 1 - k / (2 * CLK_DIV);
          exp_v = {1'b1, (k % (2 * CLK_DIV)) >= CLK_DIV, m_cfg[idx / CFG_BITS][idx % CFG_BITS], 1'b0, 1'b0};
        end else if (k >= SHIFT_CYC && k < BUSY_CYC) begin
          exp_v = 5'b11010 & 5'b10010;
          mask = 5'b11011;
        end else if (k == BUSY_CYC) begin
          exp_v = 5'b00001;
          m_active = 0;
        end
      end
      check("serial_cycle{busy,clk,data,load,done}", 32'({busy, sclk, sdata, sload, done} & mask), 32'(exp_v & mask));
      check("pwr_ctrl_out", 32'(pwr), m_pwr);
    end
  end

  // Monitor: counts edges/pulses and captures data on each rising serial clock.
  int mon_rise = 0, mon_load = 0, mon_done = 0, mon_busy = 0;
  logic prev_sclk = 0;
  bit cap[$];
  always @(negedge clk) begin
    if (sclk === 1'b1 && prev_sclk === 1'b0) begin
      mon_rise++;
      cap.push_back(sdata);
    end
    prev_sclk = sclk;
    if (sload === 1'b1) mon_load++;
    if (done === 1'b1) mon_done++;
    if (busy === 1'b1) mon_busy++;
  end

  task automatic mon_clear();
    mon_rise = 0; mon_load = 0; mon_done = 0; mon_busy = 0;
    cap.delete();
  endtask

  function automatic logic [31:0] seg(input int off);
    logic [31:0] v;
    v = 0;
    for (int j = 0; j < CFG_BITS; j++) v = {v[30:0], 1'b0} | 32'(cap[off + j]);
    return v;
  endfunction

  // One bus request; strobe held one cycle past the ack to show ack drops anyway.
  task automatic wb_cycle(input bit w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic [31:0] rd);
    int n;
    n = 0;
    stb = 1; cyc = 1; we = w; adr = a; dat = d; sel = s;
    do begin @(posedge clk); #1; n++; end while (!ack && n < 8);
    check("ack_latency", 32'(n), 32'd1);
    rd = rdat;
    if (ack && w) model_write(a, d, s);
    @(posedge clk); #1;
    check("ack_single", 32'(ack), 32'd0);
    stb = 0; cyc = 0; we = 0;
    $display("wb %s adr=0x%08h sel=%b wdat=0x%08h rdat=0x%08h", w ? "WR" : "RD", a, s, d, rd);
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] rd;
    wb_cycle(1, a, d, s, rd);
  endtask

  task automatic wb_read(input logic [31:0] a, input string name);
    logic [31:0] rd;
    wb_cycle(0, a, 0, 4'hF, rd);
    check(name, rd, model_read(a));
  endtask

  task automatic wb_read_lit(input logic [31:0] a, input logic [31:0] exp, input string name);
    logic [31:0] rd;
    wb_cycle(0, a, 0, 4'hF, rd);
    check(name, rd, exp);
  endtask

  task automatic probe_miss(input logic [31:0] a, input logic c);
    stb = 1; cyc = c; we = 0; adr = a; sel = 4'hF;
    repeat (3) begin @(posedge clk); #1; check("no_ack_unselected", 32'(ack), 32'd0); end
    stb = 0; cyc = 0;
  endtask

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog: time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    int n;
    model_reset();
    rst = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    chk_en = 1;
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_dat", rdat, 32'd0);
    check("rst_serial", 32'({busy, sclk, sdata, sload, done}), 32'd0);

    wb_read_lit(BASE, 32'd0, "xfer_rst");
    wb_read_lit(BASE + 32'h4, 32'd0, "pwr_rst");
    for (int i = 0; i < N_PADS; i++) wb_read(cfg_adr(i), "cfg_rst");
    wb_read_lit(cfg_adr(37), 32'h0403, "cfg37_rst");
    wb_read_lit(BASE + 32'h10, 32'd0, "unmapped_rd");
    wb_read_lit(cfg_adr(38), 32'd0, "past_last_pad");
    probe_miss(32'h2400_0020, 1'b1);
    probe_miss(cfg_adr(0), 1'b0);

    wb_write(cfg_adr(0), 32'h1ABC, 4'b0001);
    wb_read_lit(cfg_adr(0), 32'h04BC, "cfg0_lane0");
    wb_write(cfg_adr(0), 32'h1ABC, 4'b0010);
    wb_read_lit(cfg_adr(0), 32'h1ABC, "cfg0_lane1");

    for (int i = 0; i < N_PADS; i++) wb_write(cfg_adr(i), $urandom, 4'hF);
    for (int i = 0; i < N_PADS; i++) wb_read(cfg_adr(i), "cfg_random");

    wb_write(BASE + 32'h4, 32'hFFFF_FFFF, 4'hF);
    wb_read_lit(BASE + 32'h4, 32'hF, "pwr_all");
    check("pwr_out_all", 32'(pwr), 32'hF);
    wb_write(BASE + 32'h4, 32'h0, 4'b1110);
    wb_read_lit(BASE + 32'h4, 32'hF, "pwr_upper_lanes");
    wb_write(BASE + 32'h4, 32'h5, 4'b0001);
    wb_read_lit(BASE + 32'h4, 32'h5, "pwr_lane0");
    wb_write(BASE + 32'h10, 32'hFFFF_FFFF, 4'hF);
    wb_read_lit(BASE + 32'h10, 32'd0, "unmapped_wr");

    wb_write(BASE, 32'h1, 4'b0010);
    wb_write(BASE, 32'hFFFF_FFFE, 4'hF);
    repeat (5) @(posedge clk);
    #1 check("no_start", 32'(busy), 32'd0);

    // Full transfer with IOCONFIG[i]=i.
    for (int i = 0; i < N_PADS; i++) wb_write(cfg_adr(i), 32'(i), 4'hF);
    mon_clear();
    wb_write(BASE, 32'h1, 4'b0001);
    repeat (50) @(posedge clk);
    #1;
    wb_write(cfg_adr(5), 32'h1FFF, 4'hF);
    wb_write(BASE, 32'h1, 4'hF);
    wb_read_lit(BASE, 32'h1, "xfer_busy_rd");
    n = 0;
    while (mon_done == 0 && n < 3000) begin @(posedge clk); #1; n++; end
    check("done_seen", 32'(mon_done), 32'd1);
    check("busy_cycles", 32'(mon_busy), 32'd1978);
    check("sclk_rises", 32'(mon_rise), 32'd494);
    check("load_cycles", 32'(mon_load), 32'd2);
    check("cap_len", 32'(cap.size()), 32'd494);
    if (cap.size() == 494) begin
      check("first_pad37", seg(0), 32'd37);
      check("pad5_seg", seg(32 * 13), 32'd5);
      check("pad1_seg", seg(36 * 13), 32'd1);
      check("last_pad0", seg(37 * 13), 32'd0);
    end
    wb_read_lit(cfg_adr(5), 32'd5, "cfg5_kept");
    repeat (30) @(posedge clk);
    #1;
    check("single_transfer", 32'(mon_done), 32'd1);
    check("idle_after", 32'(busy), 32'd0);

    // Reset in the middle of a transfer.
    mon_clear();
    wb_write(BASE, 32'h1, 4'b0001);
    n = 0;
    while (mon_rise < 100 && n < 1000) begin @(posedge clk); #1; n++; end
    check("bit100_reached", 32'(mon_rise), 32'd100);
    rst = 1;
    @(posedge clk);
    #1 rst = 0;
    model_reset();
    check("mid_rst_serial", 32'({busy, sclk, sdata, sload, done}), 32'd0);
    repeat (20) @(posedge clk);
    #1;
    check("mid_rst_no_load", 32'(mon_load), 32'd0);
    check("mid_rst_no_done", 32'(mon_done), 32'd0);
    wb_read_lit(cfg_adr(5), 32'h0403, "mid_rst_cfg5");
    wb_read_lit(BASE + 32'h4, 32'd0, "mid_rst_pwr");
    wb_read_lit(BASE, 32'd0, "mid_rst_xfer");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mprj_cfg_xfer_wb.md
# mprj_cfg_xfer_wb

Wishbone slave holding per-pad user-project IO configuration and power-control registers, with a serial transfer engine that shifts all pad configurations into the padframe's daisy-chained configuration registers. It sits on the management SoC Wishbone bus and drives the serial clock, data and load lines of the pad configuration chain. It replaces the flat register-only project control block and adds parametrised pad count and configuration width, byte-lane writes, and the serial load engine.

## Interface
- BASE_ADR, 32'h2300_0000, base address; bits [31:12] decoded
- N_PADS, 38, number of pad config registers (1..64)
- CFG_BITS, 13, config bits per pad (1..32)
- CFG_RESET, 13'h0403, reset value of every IOCONFIG register (CFG_BITS wide)
- N_PWR, 4, power-control bits (1..32)
- CLK_DIV, 2, serial_clock half-period in wb_clk_i cycles (>=1)

- wb_clk_i  in  1  sole clock
- wb_rst_i  in  1  reset, synchronous, active-high
- wb_stb_i, wb_cyc_i, wb_we_i  in  1 each  Wishbone strobe, cycle, write enable
- wb_sel_i  in  4  byte-lane selects
- wb_adr_i  in  32  byte address
- wb_dat_i  in  32  write data
- wb_ack_o  out  1  acknowledge
- wb_dat_o  out  32  read data
- pwr_ctrl_out  out  N_PWR  PWRDATA register contents
- serial_clock  out  1  chain shift clock
- serial_data_out  out  1  chain shift data
- serial_load  out  1  chain parallel-load strobe
- xfer_busy  out  1  transfer in progress
- xfer_done  out  1  one-cycle pulse at transfer completion

## Operation
- Register map (offset from BASE_ADR): 0x00 XFER, 0x04 PWRDATA, 0x20+4*i IOCONFIG[i], i=0..N_PADS-1.
- Select = stb & cyc & adr[31:12]==BASE_ADR[31:12]. Unmapped offsets within the window: ack, read 0, write ignored.
- Writes honour wb_sel_i per byte; bits above register width discarded; reads zero-extended.
- XFER read: bit0 = xfer_busy, others 0. XFER write with dat[0]=1 (lane 0 selected) and engine idle starts a transfer; ignored while busy.
- IOCONFIG writes while busy: acked, discarded. PWRDATA writes always take effect.
- Engine states: IDLE -> SHIFT -> LOAD -> IDLE.
  - SHIFT: N_PADS*CFG_BITS bits sent, pad N_PADS-1 first, each pad MSB first; last bit is IOCONFIG[0][0]. Each bit lasts 2*CLK_DIV cycles: serial_data_out stable whole bit, serial_clock low first CLK_DIV cycles, high second CLK_DIV cycles.
  - LOAD: serial_load=1 for CLK_DIV cycles, serial_clock=0.
  - Exit LOAD -> IDLE, xfer_done pulses 1 cycle.
- Bit counter and divider counter sized by $clog2; no wrap beyond final bit.
- Reset values: wb_ack_o=0, wb_dat_o=0, IOCONFIG=CFG_RESET, PWRDATA=0, serial_clock/data/load=0, xfer_busy=0, xfer_done=0, state IDLE.
- Reset mid-transfer: next edge returns all outputs to reset values, no load pulse emitted.

## Timing
- ack: request first seen in cycle T (ack low) -> wb_ack_o=1 in T+1, wb_dat_o valid same cycle; ack forced 0 in T+2 even if stb held. One ack per request; no back-to-back acks.
- Register write takes effect at the ack edge; read in following request returns new value.
- XFER start acked at T+1 -> xfer_busy=1 from T+2; first bit on serial_data_out at T+2.
- xfer_busy duration = 2*CLK_DIV*N_PADS*CFG_BITS + CLK_DIV cycles; xfer_done pulses the cycle busy falls.
- Defaults: 494 bits, busy = 1978 cycles.

## Test plan
- Reset, read all IOCONFIG -> 0x0403 each; PWRDATA -> 0; XFER -> 0; serial lines 0.
- Write random 13-bit value to each IOCONFIG[i], read back -> equal; write 0xFFFF_FFFF to PWRDATA -> read 0xF, pwr_ctrl_out=4'hF.
- Write IOCONFIG[0]=0x1ABC with sel=4'b0001 after reset -> reads 0x04BC.
- Load IOCONFIG[i]=i, write XFER=1 -> xfer_busy 1978 cycles, 494 rising serial_clock edges, sampled bitstream equals pad 37..0 MSB-first concatenation, serial_load high 2 cycles, xfer_done one pulse.
- During transfer write IOCONFIG[5]=0x1FFF and XFER=1 -> both acked, IOCONFIG[5] unchanged, single transfer only.
- Assert wb_rst_i at bit 100 -> next cycle busy=0, serial lines 0, no serial_load, registers at defaults.
